// File: rtl/sram_pkg.sv
// Shared types and widths for the 32-bit to 16-bit SRAM word controller.
package sram_pkg;

   localparam int SRAM_ADDR_W       = 18;
   localparam int SRAM_DATA_W       = 16;
   localparam int WORD_W            = 32;
   localparam int WORD_IDX_W        = SRAM_ADDR_W - 1;
   localparam int DEFAULT_BASE_ADDR = 1024;
   // Wide enough for WAIT_CYCLES up to 7.
   localparam int PHASE_CNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter; phase_last is high on the final cycle of an SRAM phase.
module sram_phase_timer
   import sram_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic phase_last
);

   localparam logic [PHASE_CNT_W-1:0] LOAD_VAL = PHASE_CNT_W'(WAIT_CYCLES - 1);

   logic [PHASE_CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign phase_last = (cnt == '0);

endmodule

// File: rtl/sram_word_controller.sv
// Splits each 32-bit MEM-stage access into a low then high 16-bit SRAM phase.
// Define SRAM_LAST_READ_CACHE_EN to add a one-entry last-read cache.
module sram_word_controller
   import sram_pkg::*;
#(
   parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [WORD_W-1:0]      address,
   input  logic [WORD_W-1:0]      write_data,
   output logic [WORD_W-1:0]      read_data,
   output logic                   ready,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N
);

   // Handshake: the pipeline holds wr_en/rd_en and its operands until it sees
   // ready=1; the cycle with ready=1 and a request is the completing cycle.

   state_t                 state, next_state;
   logic                   request, accept, load_timer, phase_last, cache_hit;
   logic [WORD_IDX_W-1:0]  word_in, req_word;
   logic                   req_write;
   logic [WORD_W-1:0]      req_data;
   logic                   dq_oe;
   logic [SRAM_DATA_W-1:0] dq_out;

   assign request = wr_en | rd_en;
   assign word_in = WORD_IDX_W'((address - WORD_W'(BASE_ADDR)) >> 2);
   assign accept  = (state == IDLE) && request && !cache_hit;

   sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_timer),
      .phase_last (phase_last)
   );

`ifdef SRAM_LAST_READ_CACHE_EN
   logic                  cache_valid;
   logic [WORD_IDX_W-1:0] cache_tag;
   logic [WORD_W-1:0]     cache_data;

   assign cache_hit = rd_en && !wr_en && cache_valid && (cache_tag == word_in);

   // Write-through: a completed write to the cached word keeps the entry coherent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
         cache_tag   <= '0;
         cache_data  <= '0;
      end else if (state == HIGH && phase_last) begin
         if (!req_write) begin
            cache_valid <= 1'b1;
            cache_tag   <= req_word;
            cache_data  <= {SRAM_DQ, read_data[SRAM_DATA_W-1:0]};
         end else if (cache_valid && cache_tag == req_word) begin
            cache_data <= req_data;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      load_timer = 1'b0;
      case (state)
         IDLE: begin
            if (cache_hit) begin
               next_state = DONE;
            end else if (request) begin
               next_state = LOW;
               load_timer = 1'b1;
            end
         end
         LOW: begin
            if (phase_last) begin
               next_state = HIGH;
               load_timer = 1'b1;
            end
         end
         HIGH: begin
            if (phase_last) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ready     = 1'b0;
      SRAM_CE_N = 1'b1;
      SRAM_UB_N = 1'b1;
      SRAM_LB_N = 1'b1;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      SRAM_ADDR = '0;
      dq_oe     = 1'b0;
      dq_out    = '0;
      case (state)
         IDLE: ready = !request;
         DONE: ready = 1'b1;
         LOW, HIGH: begin
            SRAM_CE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
            SRAM_WE_N = !req_write;
            SRAM_OE_N = req_write;
            SRAM_ADDR = {req_word, (state == HIGH)};
            dq_oe     = req_write;
            dq_out    = (state == HIGH) ? req_data[WORD_W-1:SRAM_DATA_W]
                                        : req_data[SRAM_DATA_W-1:0];
         end
         default: ready = 1'b0;
      endcase
   end

   assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};

   // Operands are frozen at acceptance so the pipeline may change them later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_write <= 1'b0;
         req_word  <= '0;
         req_data  <= '0;
      end else if (accept) begin
         req_write <= wr_en;
         req_word  <= word_in;
         req_data  <= write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data <= '0;
      end else if (state == LOW && phase_last && !req_write) begin
         read_data[SRAM_DATA_W-1:0] <= SRAM_DQ;
      end else if (state == HIGH && phase_last && !req_write) begin
         read_data[WORD_W-1:SRAM_DATA_W] <= SRAM_DQ;
`ifdef SRAM_LAST_READ_CACHE_EN
      end else if (state == IDLE && cache_hit) begin
         read_data <= cache_data;
`endif
      end
   end

endmodule

// File: tb/tb_sram_word_controller.sv
// Directed bench for sram_word_controller: behavioural SRAM, word-level model, per-cycle pin compare.
module tb_sram_word_controller;

   localparam int          W    = 2;
   localparam logic [31:0] BASE = 32'd1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        ub_n, lb_n, we_n, ce_n, oe_n;

   sram_word_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .SRAM_DQ    (sram_dq),
      .SRAM_ADDR  (sram_addr),
      .SRAM_UB_N  (ub_n),
      .SRAM_LB_N  (lb_n),
      .SRAM_WE_N  (we_n),
      .SRAM_CE_N  (ce_n),
      .SRAM_OE_N  (oe_n)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- behavioural SRAM ----------------
   logic [15:0] sram [0:1023];
   logic        sram_init = 1'b1;

   function automatic logic [15:0] init_half(input int h);
      return 16'(32'h3C00 + h * 7);
   endfunction

   assign sram_dq = (!ce_n && !oe_n && we_n) ? sram[sram_addr[9:0]] : 16'bz;

   always @(posedge clk) begin
      if (sram_init) begin
         for (int i = 0; i < 1024; i++) sram[i] <= init_half(i);
      end else if (!ce_n && !we_n) begin
         sram[sram_addr[9:0]] <= sram_dq;
      end
   end

   // ---------------- word-level model ----------------
   logic [31:0] mw [int];
   bit          c_valid = 1'b0;
   logic [16:0] c_tag = '0;

   function automatic logic [16:0] word_of(input logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE) >> 2;
      return off[16:0];
   endfunction

   function automatic logic [31:0] model_word(input logic [16:0] w);
      int k;
      k = int'(w);
      if (mw.exists(k)) return mw[k];
      return {init_half(2 * k + 1), init_half(2 * k)};
   endfunction

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   bit          check_en = 1'b0;
   logic        exp_ready, exp_ce_n, exp_we_n, exp_oe_n;
   logic [17:0] exp_addr;
   logic [15:0] exp_dq;
   logic [31:0] exp_rd;

   task automatic set_idle_exp(input logic rdy);
      exp_ready = rdy;
      exp_ce_n  = 1'b1;
      exp_we_n  = 1'b1;
      exp_oe_n  = 1'b1;
      exp_addr  = '0;
      exp_dq    = 16'bz;
   endtask

   task automatic set_phase_exp(input bit wr, input logic [16:0] w, input bit hi, input logic [31:0] d);
      exp_ready = 1'b0;
      exp_ce_n  = 1'b0;
      exp_we_n  = !wr;
      exp_oe_n  = wr;
      exp_addr  = {w, hi};
      exp_dq    = hi ? d[31:16] : d[15:0];
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("ready", ready, exp_ready);
         check("ce_n", ce_n, exp_ce_n);
         check("ub_n", ub_n, exp_ce_n);
         check("lb_n", lb_n, exp_ce_n);
         check("we_n", we_n, exp_we_n);
         check("oe_n", oe_n, exp_oe_n);
         check("sram_addr", sram_addr, exp_addr);
         check("sram_dq", sram_dq, exp_dq);
         check("read_data", read_data, exp_rd);
      end
   end

   // ---------------- driver ----------------
   // Called just after a rising edge; returns just after a rising edge.
   task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input bit hold,
                         output logic [31:0] got, output int lat);
      logic [16:0] w;
      logic [31:0] cur;
      bit          hit;
      w   = word_of(addr);
      cur = model_word(w);
      hit = 1'b0;
`ifdef SRAM_LAST_READ_CACHE_EN
      hit = !wr && rd && c_valid && (c_tag == w);
`endif
      wr_en      = wr;
      rd_en      = rd;
      address    = addr;
      write_data = data;
      set_idle_exp(1'b0);
      lat = 0;
      @(negedge clk);
      if (!ready) lat++;
      @(posedge clk); #1;
      if (!hit) begin
         for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < W; c++) begin
               set_phase_exp(wr, w, ph[0], wr ? data : cur);
               @(negedge clk);
               if (!ready) lat++;
               @(posedge clk); #1;
               if (!wr && c == W - 1) begin
                  if (ph == 0) exp_rd[15:0] = cur[15:0];
                  else         exp_rd[31:16] = cur[31:16];
               end
            end
         end
         if (wr) begin
            mw[int'(w)] = data;
         end else begin
            c_valid = 1'b1;
            c_tag   = w;
         end
      end else begin
         exp_rd = cur;
      end
      set_idle_exp(1'b1);
      @(negedge clk);
      got = read_data;
      @(posedge clk); #1;
      if (!hold) begin
         wr_en = 1'b0;
         rd_en = 1'b0;
         set_idle_exp(1'b1);
      end
   endtask

   // Starts a write and asserts reset during the first cycle of its high phase.
   task automatic write_then_reset(input logic [31:0] addr, input logic [31:0] data);
      logic [16:0] w;
      w          = word_of(addr);
      wr_en      = 1'b1;
      address    = addr;
      write_data = data;
      set_idle_exp(1'b0);
      @(posedge clk); #1;
      for (int c = 0; c < W; c++) begin
         set_phase_exp(1'b1, w, 1'b0, data);
         @(posedge clk); #1;
      end
      set_phase_exp(1'b1, w, 1'b1, data);
      #2;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      c_valid = 1'b0;
      exp_rd  = '0;
      set_idle_exp(1'b1);
      #1;
      check("rst_ce_n", ce_n, 1'b1);
      check("rst_we_n", we_n, 1'b1);
      check("rst_oe_n", oe_n, 1'b1);
      check("rst_dq", sram_dq, 16'bz);
      check("rst_read_data", read_data, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", ready, 1'b1);
      @(posedge clk); #1;
   endtask

   // ---------------- main sequence ----------------
   logic [31:0] got;
   int          lat;

   initial begin
      set_idle_exp(1'b1);
      exp_rd = '0;
      repeat (2) @(posedge clk);
      #1;
      sram_init = 1'b0;
      check_en  = 1'b1;
      @(negedge clk);
      check("reset_read_data", read_data, 32'h0);
      check("reset_sram_addr", sram_addr, 18'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Word write/read at the base address.
      access(1'b1, 1'b0, 32'd1024, 32'h1234_5678, 1'b0, got, lat);
      check("write_latency", lat, 5);
      check("sram_hw0", sram[0], 16'h5678);
      check("sram_hw1", sram[1], 16'h1234);
      access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, got, lat);
      check("read_1024", got, 32'h1234_5678);
      check("read_latency", lat, 5);

      // Neighbouring word keeps its prior contents.
      access(1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF, 1'b0, got, lat);
      access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, got, lat);
      check("read_1028_prior", got, 32'h3C15_3C0E);
      access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, got, lat);
      check("read_1032", got, 32'hDEAD_BEEF);

      // Both requests at once behave as a write.
      access(1'b1, 1'b1, 32'd1040, 32'h0000_00AA, 1'b0, got, lat);
      check("both_sram_hw8", sram[8], 16'h00AA);
      access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0, got, lat);
      check("read_1040", got, 32'h0000_00AA);

      // Requests held across DONE: one sequence each.
      access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b1, got, lat);
      check("b2b_first", got, 32'hDEAD_BEEF);
      access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b1, got, lat);
      check("b2b_second", got, 32'h0000_00AA);
      access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, got, lat);
      check("b2b_third", got, 32'h3C15_3C0E);

      // Word index beyond 17 bits wraps onto halfword 0.
      access(1'b1, 1'b0, 32'h0008_0400, 32'h1111_2222, 1'b0, got, lat);
      check("wrap_sram_hw0", sram[0], 16'h2222);
      access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, got, lat);
      check("wrap_read", got, 32'h1111_2222);

      write_then_reset(32'd1048, 32'h5555_AAAA);

      // Repeated read, then write and read back.
      access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, got, lat);
      check("reread_first_latency", lat, 5);
      access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, got, lat);
      check("reread_second", got, 32'h1111_2222);
`ifdef SRAM_LAST_READ_CACHE_EN
      check("cache_hit_latency", lat, 1);
`else
      check("reread_second_latency", lat, 5);
`endif
      access(1'b1, 1'b0, 32'd1024, 32'h0BAD_F00D, 1'b0, got, lat);
      access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, got, lat);
      check("read_after_update", got, 32'h0BAD_F00D);

      repeat (2) @(posedge clk);
      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

endmodule
